// File: rtl/sparse_enc_pkg.sv
// Shared types and sizes for the sparse chunk encoder.
//   BUS_SIZE   : bytes per dense beat (sparsemap width)
//   MEM_SIZE   : bytes per chunk
//   WR_CYC_NUM : beats per chunk
`ifndef BUS_SIZE
`define BUS_SIZE 32
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 128
`endif

package sparse_enc_pkg;
    localparam int BUS_SIZE   = `BUS_SIZE;
    localparam int MEM_SIZE   = `MEM_SIZE;
    localparam int WR_CYC_NUM = MEM_SIZE / BUS_SIZE;
    localparam int CNT_W      = $clog2(WR_CYC_NUM);
    localparam int PCNT_W     = $clog2(BUS_SIZE) + 1;
    localparam int NZ_W       = $clog2(MEM_SIZE) + 1;

    typedef logic [BUS_SIZE-1:0][7:0] beat_t;
    typedef enum logic [1:0] {IDLE, FILL, WAIT} enc_state_e;
endpackage

// File: rtl/sparse_beat_compactor.sv
// Combinational beat compactor.
//   beat      : dense input bytes
//   sparsemap : bit k set when byte k is nonzero
//   compacted : nonzero bytes packed toward slot 0, unused slots zero
//   popcount  : number of nonzero bytes in the beat
module sparse_beat_compactor
    import sparse_enc_pkg::*;
(
    input  beat_t                beat,
    output logic [BUS_SIZE-1:0]  sparsemap,
    output beat_t                compacted,
    output logic [PCNT_W-1:0]    popcount
);
    // slot[k]: number of nonzero bytes below k, i.e. destination slot of byte k
    logic [BUS_SIZE-1:0][PCNT_W-1:0] slot;

    always_comb begin
        logic [PCNT_W-1:0] acc;
        acc       = '0;
        sparsemap = '0;
        slot      = '0;
        for (int k = 0; k < BUS_SIZE; k++) begin
            sparsemap[k] = |beat[k];
            slot[k]      = acc;
            acc          = acc + {{(PCNT_W-1){1'b0}}, sparsemap[k]};
        end
        popcount = acc;
    end

    // A byte can only land at or below its own index, so slot j scans k >= j.
    always_comb begin
        compacted = '0;
        for (int j = 0; j < BUS_SIZE; j++) begin
            for (int k = j; k < BUS_SIZE; k++) begin
                if (sparsemap[k] && (slot[k] == PCNT_W'(j)))
                    compacted[j] = compacted[j] | beat[k];
            end
        end
    end
endmodule

// File: rtl/sparse_chunk_encoder.sv
// Sparse chunk encoder: dense beats in, registered sparsemap + compacted
// bytes out as buffer writes into a double-buffered chunk store.
//   clk_i, rst_i (async, active-low)
//   dense_valid_i/dense_ready_o/dense_data_i : dense beat input
//   sparsemap_o, nonzero_data_o               : encoded beat, one cycle later
//   wr_valid_o, wr_count_o, wr_sel_o          : buffer write strobe/index/bank
//   chunk_done_o, chunk_bank_o, chunk_nz_count_o : end-of-chunk report
//   buf_release_i, buf_release_sel_i          : consumer frees a bank
//   bank_full_o                               : per-bank occupancy
module sparse_chunk_encoder
    import sparse_enc_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                dense_valid_i,
    output logic                dense_ready_o,
    input  beat_t               dense_data_i,
    output logic [BUS_SIZE-1:0] sparsemap_o,
    output beat_t               nonzero_data_o,
    output logic                wr_valid_o,
    output logic [CNT_W-1:0]    wr_count_o,
    output logic                wr_sel_o,
    output logic                chunk_done_o,
    output logic                chunk_bank_o,
    output logic [NZ_W-1:0]     chunk_nz_count_o,
    input  logic                buf_release_i,
    input  logic                buf_release_sel_i,
    output logic [1:0]          bank_full_o
);
    logic [BUS_SIZE-1:0] map;
    beat_t               comp;
    logic [PCNT_W-1:0]   pcnt;

    sparse_beat_compactor u_compactor (
        .beat      (dense_data_i),
        .sparsemap (map),
        .compacted (comp),
        .popcount  (pcnt)
    );

    logic             wr_ptr;
    logic [CNT_W-1:0] beat_cnt;
    logic [NZ_W-1:0]  nz_acc;
    enc_state_e       state;

    logic             accept;
    logic             last_beat;
    logic [NZ_W-1:0]  nz_total;
    logic [1:0]       bank_full_nxt;

    // Ready depends only on registered occupancy; gated by reset so it reads 0 in reset.
    assign dense_ready_o = rst_i & ~bank_full_o[wr_ptr];
    assign accept        = dense_valid_i & dense_ready_o;
    assign last_beat     = (beat_cnt == CNT_W'(WR_CYC_NUM - 1));
    assign nz_total      = nz_acc + NZ_W'(pcnt);

    // Release clears first, completion sets second; they never target the same bank.
    always_comb begin
        bank_full_nxt = bank_full_o;
        if (buf_release_i)
            bank_full_nxt[buf_release_sel_i] = 1'b0;
        if (accept && last_beat)
            bank_full_nxt[wr_ptr] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sparsemap_o      <= '0;
            nonzero_data_o   <= '0;
            wr_valid_o       <= 1'b0;
            wr_count_o       <= '0;
            wr_sel_o         <= 1'b0;
            chunk_done_o     <= 1'b0;
            chunk_bank_o     <= 1'b0;
            chunk_nz_count_o <= '0;
            bank_full_o      <= 2'b00;
            wr_ptr           <= 1'b0;
            beat_cnt         <= '0;
            nz_acc           <= '0;
            state            <= IDLE;
        end else begin
            wr_valid_o   <= accept;
            chunk_done_o <= accept && last_beat;
            bank_full_o  <= bank_full_nxt;

            if (accept) begin
                sparsemap_o    <= map;
                nonzero_data_o <= comp;
                wr_count_o     <= beat_cnt;
                wr_sel_o       <= wr_ptr;
                if (last_beat) begin
                    beat_cnt         <= '0;
                    nz_acc           <= '0;
                    wr_ptr           <= ~wr_ptr;
                    chunk_bank_o     <= wr_ptr;
                    chunk_nz_count_o <= nz_total;
                end else begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    nz_acc   <= nz_total;
                end
            end

            case (state)
                IDLE: if (accept) state <= FILL;
                FILL: if (accept && last_beat)
                          state <= bank_full_nxt[~wr_ptr] ? WAIT : IDLE;
                WAIT: if (!bank_full_nxt[wr_ptr]) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sparse_chunk_encoder.sv
module tb_sparse_chunk_encoder;
    import sparse_enc_pkg::*;

    logic                clk_i;
    logic                rst_i;
    logic                dense_valid_i;
    logic                dense_ready_o;
    beat_t               dense_data_i;
    logic [BUS_SIZE-1:0] sparsemap_o;
    beat_t               nonzero_data_o;
    logic                wr_valid_o;
    logic [CNT_W-1:0]    wr_count_o;
    logic                wr_sel_o;
    logic                chunk_done_o;
    logic                chunk_bank_o;
    logic [NZ_W-1:0]     chunk_nz_count_o;
    logic                buf_release_i;
    logic                buf_release_sel_i;
    logic [1:0]          bank_full_o;

    sparse_chunk_encoder dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .dense_valid_i     (dense_valid_i),
        .dense_ready_o     (dense_ready_o),
        .dense_data_i      (dense_data_i),
        .sparsemap_o       (sparsemap_o),
        .nonzero_data_o    (nonzero_data_o),
        .wr_valid_o        (wr_valid_o),
        .wr_count_o        (wr_count_o),
        .wr_sel_o          (wr_sel_o),
        .chunk_done_o      (chunk_done_o),
        .chunk_bank_o      (chunk_bank_o),
        .chunk_nz_count_o  (chunk_nz_count_o),
        .buf_release_i     (buf_release_i),
        .buf_release_sel_i (buf_release_sel_i),
        .bank_full_o       (bank_full_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a beat for one edge; outputs are sampled 1 time unit after that edge.
    task automatic send(input beat_t d);
        chk("send_ready", dense_ready_o, 1'b1);
        dense_data_i  = d;
        dense_valid_i = 1'b1;
        @(posedge clk_i); #1;
        dense_valid_i = 1'b0;
    endtask

    task automatic release_bank(input logic sel);
        buf_release_i     = 1'b1;
        buf_release_sel_i = sel;
        @(posedge clk_i); #1;
        buf_release_i     = 1'b0;
    endtask

    beat_t b_two, b_ones, b_hi;

    initial begin
        rst_i = 1'b0; dense_valid_i = 1'b0; dense_data_i = '0;
        buf_release_i = 1'b0; buf_release_sel_i = 1'b0;

        b_two = '0; b_two[0] = 8'h05; b_two[2] = 8'h07;
        b_ones = {BUS_SIZE{8'h01}};
        b_hi = '0; b_hi[31] = 8'hFF; b_hi[16] = 8'h33;

        // reset state
        repeat (3) @(posedge clk_i); #1;
        chk("rst_wr_valid", wr_valid_o, 0);
        chk("rst_sparsemap", sparsemap_o, 0);
        chk("rst_nonzero", nonzero_data_o, 0);
        chk("rst_chunk_done", chunk_done_o, 0);
        chk("rst_nz_count", chunk_nz_count_o, 0);
        chk("rst_bank_full", bank_full_o, 0);
        chk("rst_ready_low", dense_ready_o, 0);
        rst_i = 1'b1; #1;
        chk("rst_ready_high", dense_ready_o, 1);

        // single beat: bytes 0 and 2 nonzero
        send(b_two);
        chk("one_wr_valid", wr_valid_o, 1);
        chk("one_sparsemap", sparsemap_o, 32'h0000_0005);
        chk("one_nonzero", nonzero_data_o, 256'h0705);
        chk("one_wr_count", wr_count_o, 0);
        chk("one_wr_sel", wr_sel_o, 0);
        chk("one_done", chunk_done_o, 0);
        @(posedge clk_i); #1;
        chk("one_valid_drop", wr_valid_o, 0);
        rst_i = 1'b0; @(posedge clk_i); #1; rst_i = 1'b1; #1;

        // chunk 0: all 0x01
        for (int i = 0; i < 4; i++) begin
            send(b_ones);
            chk("c0_wr_count", wr_count_o, i);
            chk("c0_wr_sel", wr_sel_o, 0);
            chk("c0_sparsemap", sparsemap_o, 32'hFFFF_FFFF);
            chk("c0_nonzero", nonzero_data_o, b_ones);
            chk("c0_done", chunk_done_o, i == 3);
        end
        chk("c0_bank", chunk_bank_o, 0);
        chk("c0_nz", chunk_nz_count_o, 128);
        chk("c0_full", bank_full_o, 2'b01);

        // chunk 1: bytes 16 and 31 nonzero, on bank 1
        for (int i = 0; i < 4; i++) begin
            send(b_hi);
            chk("c1_wr_count", wr_count_o, i);
            chk("c1_wr_sel", wr_sel_o, 1);
            chk("c1_sparsemap", sparsemap_o, 32'h8001_0000);
            chk("c1_nonzero", nonzero_data_o, 256'hFF33);
        end
        chk("c1_done", chunk_done_o, 1);
        chk("c1_bank", chunk_bank_o, 1);
        chk("c1_nz", chunk_nz_count_o, 8);
        chk("c1_full", bank_full_o, 2'b11);
        chk("c1_ready", dense_ready_o, 0);

        // both banks full: a held beat must not be consumed
        dense_data_i = b_ones; dense_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            chk("hold_no_write", wr_valid_o, 0);
            chk("hold_ready", dense_ready_o, 0);
        end
        dense_valid_i = 1'b0;
        release_bank(1'b0);
        chk("rel0_full", bank_full_o, 2'b10);
        chk("rel0_ready", dense_ready_o, 1);
        chk("rel0_no_write", wr_valid_o, 0);

        // chunk 2: all-zero beats, on bank 0
        for (int i = 0; i < 4; i++) begin
            send('0);
            chk("c2_wr_valid", wr_valid_o, 1);
            chk("c2_wr_count", wr_count_o, i);
            chk("c2_wr_sel", wr_sel_o, 0);
            chk("c2_sparsemap", sparsemap_o, 0);
            chk("c2_nonzero", nonzero_data_o, 0);
        end
        chk("c2_done", chunk_done_o, 1);
        chk("c2_bank", chunk_bank_o, 0);
        chk("c2_nz", chunk_nz_count_o, 0);
        chk("c2_full", bank_full_o, 2'b11);

        release_bank(1'b1);
        chk("rel1_full", bank_full_o, 2'b01);
        chk("rel1_ready", dense_ready_o, 1);
        release_bank(1'b1);
        chk("rel1_again", bank_full_o, 2'b01);

        // partial chunk on bank 1, then reset mid-chunk
        for (int i = 0; i < 2; i++) begin
            send(b_ones);
            chk("part_wr_count", wr_count_o, i);
            chk("part_wr_sel", wr_sel_o, 1);
        end
        rst_i = 1'b0; #1;
        chk("mid_rst_wr_valid", wr_valid_o, 0);
        chk("mid_rst_full", bank_full_o, 0);
        chk("mid_rst_done", chunk_done_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b1; #1;
        chk("mid_rst_ready", dense_ready_o, 1);

        // fresh chunk after reset lands on bank 0 from count 0
        for (int i = 0; i < 4; i++) begin
            send(b_two);
            chk("c3_wr_count", wr_count_o, i);
            chk("c3_wr_sel", wr_sel_o, 0);
            chk("c3_done", chunk_done_o, i == 3);
        end
        chk("c3_bank", chunk_bank_o, 0);
        chk("c3_nz", chunk_nz_count_o, 8);
        chk("c3_full", bank_full_o, 2'b01);
        @(posedge clk_i); #1;
        chk("c3_done_pulse", chunk_done_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sparse_chunk_encoder.md
Name: sparse_chunk_encoder

Overview:
- Upstream writer for the compute unit's sparse operand buffers.
- Accepts dense BUS_SIZE-byte beats and produces, per beat, a zero/nonzero sparsemap plus nonzero bytes compacted toward index 0.
- Drives the buffer write interface (valid/count/sel) into a double-buffered chunk store of MEM_SIZE bytes.
- Tracks bank occupancy and back-pressures the dense source when the target bank is still owned by the consumer.

Parameters:
- BUS_SIZE, `BUS_SIZE (32): bytes per beat; sparsemap width.
- MEM_SIZE, `MEM_SIZE (128): bytes per chunk.
- WR_CYC_NUM, MEM_SIZE/BUS_SIZE (4), localparam: beats per chunk.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- dense_valid_i  in  1  dense beat valid.
- dense_ready_o  out  1  encoder can accept a beat.
- dense_data_i  in  BUS_SIZE x 8  dense bytes; byte k maps to sparsemap bit k.
- sparsemap_o  out  BUS_SIZE  bit k = (dense byte k != 0).
- nonzero_data_o  out  BUS_SIZE x 8  compacted nonzero bytes; unused slots are 0.
- wr_valid_o  out  1  buffer write strobe.
- wr_count_o  out  $clog2(WR_CYC_NUM)  beat index within the chunk.
- wr_sel_o  out  1  bank being written.
- chunk_done_o  out  1  pulse on the last beat of a chunk.
- chunk_bank_o  out  1  bank just completed; valid with chunk_done_o.
- chunk_nz_count_o  out  $clog2(MEM_SIZE)+1  total nonzero bytes in the chunk; valid with chunk_done_o.
- buf_release_i  in  1  consumer frees a bank.
- buf_release_sel_i  in  1  bank being freed.
- bank_full_o  out  2  per-bank occupancy flags.

Behaviour:
- Reset values: all outputs 0; write pointer = 0; beat counter = 0; nz accumulator = 0; bank_full = 2'b00; FSM = IDLE. dense_ready_o = 1 in the first cycle after reset deasserts.
- Transfer occurs when dense_valid_i & dense_ready_o. The output side has no backpressure.
- Latency: a beat accepted in cycle N appears on sparsemap_o, nonzero_data_o, wr_count_o and wr_sel_o in cycle N+1, with wr_valid_o = 1 for exactly that cycle.
- Compaction: output slot j holds the j-th nonzero byte in ascending k order. Slots from popcount(sparsemap) upward are 0.
- Counter: increments per accepted beat and wraps WR_CYC_NUM-1 -> 0. nz_acc accumulates popcount per beat and clears at chunk end. Max value MEM_SIZE fits without saturation.
- Last beat (counter = WR_CYC_NUM-1), accepted in cycle N; all of the following are visible in N+1:
  - chunk_done_o = 1, chunk_bank_o = old pointer, chunk_nz_count_o = nz_acc + popcount.
  - bank_full[old ptr] is set.
  - Pointer toggles.
- dense_ready_o = !bank_full[ptr] (registered state only; no combinational path from dense_valid_i).
- Release: buf_release_i in cycle M clears bank_full[buf_release_sel_i] at the end of M, so ready can rise in M+1. Releasing an already-free bank is ignored.
- Simultaneous chunk completion on bank b and release of bank !b: both take effect.
- Completion and release on the same bank cannot occur, because the bank being filled is never full.
- FSM:
  - IDLE (counter 0, bank free) -> FILL on an accepted beat.
  - FILL -> IDLE on last beat if bank_full[new ptr] = 0; -> WAIT if it is 1.
  - WAIT (ready = 0) -> IDLE when the pointed bank is released.
- Reset mid-chunk: partial chunk is discarded; all state returns to reset values; no chunk_done_o is issued.

Decomposition:
- Package sparse_enc_pkg:
  - BUS_SIZE, MEM_SIZE, WR_CYC_NUM (derived from the global include macros).
  - Typedef beat_t = logic [BUS_SIZE-1:0][7:0].
  - Typedef enc_state_e {IDLE, FILL, WAIT}.
- Sub-module sparse_beat_compactor: combinational. Takes beat_t in; produces sparsemap, compacted beat and popcount using prefix-sum slot indices. The top level registers its outputs.

Test Plan:
- Reset: hold rst_i = 0 for 3 cycles -> all outputs 0, bank_full_o = 2'b00. Release reset -> dense_ready_o = 1.
- Single beat with byte0 = 0x05, byte2 = 0x07, others 0 -> next cycle wr_valid_o = 1, sparsemap_o = 0x00000005, nonzero_data_o[0] = 0x05, [1] = 0x07, rest 0, wr_count_o = 0, wr_sel_o = 0.
- Four beats of all 0x01 -> wr_count_o 0,1,2,3. chunk_done_o on beat 3 with chunk_bank_o = 0, chunk_nz_count_o = 128, bank_full_o = 2'b01. Next beat has wr_sel_o = 1.
- Two full chunks, no release -> bank_full_o = 2'b11 and dense_ready_o = 0; a held valid beat is not consumed. Pulse buf_release_i with sel = 0 -> ready = 1 next cycle; the third chunk writes wr_sel_o = 0.
- All-zero chunk -> sparsemap_o = 0 and nonzero_data_o = 0 on every beat; chunk_done_o still fires with chunk_nz_count_o = 0.
- Assert rst_i = 0 after 2 beats of a chunk -> wr_valid_o = 0 and bank_full_o = 0. The next 4 beats form a chunk on bank 0 with wr_count_o starting at 0.
